// File: rtl/fifo_sync_ctrl.sv
// Pointer/flag controller for a single-clock FIFO built around an external fifomem array.
// Optional watermark flags are enabled by defining FIFO_CTRL_WATERMARK_EN.
module fifo_sync_ctrl #(
  parameter int address_Size = 3,
  parameter int af_Level     = 6,
  parameter int ae_Level     = 1
) (
  input  logic                  Clk,
  input  logic                  Rst,
  input  logic                  w_Req,
  input  logic                  r_Req,
  input  logic                  flush,
  output logic                  w_Enable,
  output logic [address_Size-1:0] w_Addr,
  output logic [address_Size-1:0] r_Addr,
  output logic                  fifo_Full,
  output logic                  fifo_Empty,
  output logic [address_Size:0] fifo_Count,
  output logic                  almost_Full,
  output logic                  almost_Empty,
  output logic                  overflow_Err,
  output logic                  underflow_Err
);

  localparam int DEPTH = 1 << address_Size;
  localparam logic [address_Size:0] PTR_ONE = (address_Size+1)'(1);

  typedef enum logic {RUN, FLUSH} state_t;

  state_t                state_q;
  logic [address_Size:0] w_ptr_q, r_ptr_q;
  logic [address_Size:0] w_ptr_d, r_ptr_d;
  logic                  overflow_q, underflow_q;
  logic                  running;
  logic                  push, pop;

  // All status flags decode the registered pointers only.
  assign fifo_Empty = (w_ptr_q == r_ptr_q);
  assign fifo_Full  = (w_ptr_q[address_Size] != r_ptr_q[address_Size]) &&
                      (w_ptr_q[address_Size-1:0] == r_ptr_q[address_Size-1:0]);
  assign fifo_Count = w_ptr_q - r_ptr_q;
  assign w_Addr     = w_ptr_q[address_Size-1:0];
  assign r_Addr     = r_ptr_q[address_Size-1:0];

  assign running  = (state_q == RUN);
  // The cycle that raises flush (and any Rst cycle) accepts nothing.
  assign push     = w_Req & ~fifo_Full  & running & ~flush & ~Rst;
  assign pop      = r_Req & ~fifo_Empty & running & ~flush & ~Rst;
  assign w_Enable = push;

  assign w_ptr_d = push ? (w_ptr_q + PTR_ONE) : w_ptr_q;
  assign r_ptr_d = pop  ? (r_ptr_q + PTR_ONE) : r_ptr_q;

  assign overflow_Err  = overflow_q;
  assign underflow_Err = underflow_q;

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q     <= RUN;
      w_ptr_q     <= '0;
      r_ptr_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      case (state_q)
        RUN: begin
          if (w_Req && fifo_Full) overflow_q <= 1'b1;
          if (r_Req && fifo_Empty) underflow_q <= 1'b1;
          if (flush) begin
            state_q <= FLUSH;
            w_ptr_q <= '0;
            r_ptr_q <= '0;
          end else begin
            w_ptr_q <= w_ptr_d;
            r_ptr_q <= r_ptr_d;
          end
        end
        FLUSH: begin
          w_ptr_q <= '0;
          r_ptr_q <= '0;
          state_q <= flush ? FLUSH : RUN;
        end
        default: state_q <= RUN;
      endcase
    end
  end

`ifdef FIFO_CTRL_WATERMARK_EN
  localparam logic [address_Size:0] AF_CNT = (address_Size+1)'(af_Level);
  localparam logic [address_Size:0] AE_CNT = (address_Size+1)'(ae_Level);

  if (!(ae_Level < af_Level && af_Level <= DEPTH)) begin : g_bad_levels
    $error("fifo_sync_ctrl: need ae_Level < af_Level <= depth");
  end

  assign almost_Full  = (fifo_Count >= AF_CNT);
  assign almost_Empty = (fifo_Count <= AE_CNT);
`else
  if (af_Level < 0 || ae_Level < 0 || DEPTH < 2) begin : g_bad_levels
    $error("fifo_sync_ctrl: watermark levels must be non-negative");
  end

  assign almost_Full  = 1'b0;
  assign almost_Empty = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_sync_ctrl.sv
// Bench for fifo_sync_ctrl: occupancy/queue reference model, per-cycle compare, emulated fifomem.
// Honors FIFO_CTRL_WATERMARK_EN the same way as the design.
module tb_fifo_sync_ctrl;

  localparam int AS    = 3;
  localparam int DEPTH = 8;

  logic         clk = 1'b0;
  logic         rst_i = 1'b0, w_req = 1'b0, r_req = 1'b0, flush_i = 1'b0;
  logic         w_en, full, empty, af, ae, ovf, unf;
  logic [AS-1:0] w_addr, r_addr;
  logic [AS:0]  count;
  logic [7:0]   wdata = 8'h00;

  fifo_sync_ctrl #(.address_Size(AS), .af_Level(6), .ae_Level(1)) dut (
    .Clk(clk), .Rst(rst_i), .w_Req(w_req), .r_Req(r_req), .flush(flush_i),
    .w_Enable(w_en), .w_Addr(w_addr), .r_Addr(r_addr),
    .fifo_Full(full), .fifo_Empty(empty), .fifo_Count(count),
    .almost_Full(af), .almost_Empty(ae),
    .overflow_Err(ovf), .underflow_Err(unf)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;
  bit chk_en  = 1'b0;

  // Reference model: total pushes/pops since the last clear, pending data, sticky errors.
  int         wtot = 0, rtot = 0;
  bit         in_flush = 1'b0, m_ovf = 1'b0, m_unf = 1'b0;
  logic [7:0] q[$];
  logic [7:0] mem [DEPTH];

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  function automatic bit exp_push();
    return !rst_i && !in_flush && !flush_i && w_req && (wtot - rtot) < DEPTH;
  endfunction

  function automatic bit exp_pop();
    return !rst_i && !in_flush && !flush_i && r_req && (wtot - rtot) > 0;
  endfunction

  // Compare process, mid-cycle with inputs stable; also emulates the fifomem array.
  always @(negedge clk) begin
    if (chk_en) begin
      int occ;
      occ = wtot - rtot;
      chk("w_Enable", int'(w_en), int'(exp_push()));
      chk("w_Addr", int'(w_addr), wtot % DEPTH);
      chk("r_Addr", int'(r_addr), rtot % DEPTH);
      chk("fifo_Count", int'(count), occ);
      chk("fifo_Full", int'(full), int'(occ == DEPTH));
      chk("fifo_Empty", int'(empty), int'(occ == 0));
      chk("overflow_Err", int'(ovf), int'(m_ovf));
      chk("underflow_Err", int'(unf), int'(m_unf));
`ifdef FIFO_CTRL_WATERMARK_EN
      chk("almost_Full", int'(af), int'(occ >= 6));
      chk("almost_Empty", int'(ae), int'(occ <= 1));
`else
      chk("almost_Full", int'(af), 0);
      chk("almost_Empty", int'(ae), 0);
`endif
      if (exp_pop() && q.size() > 0) chk("read_Data", int'(mem[r_addr]), int'(q[0]));
      if (w_en) mem[w_addr] = wdata;
    end
  end

  always @(posedge clk) begin
    if (rst_i) begin
      wtot = 0; rtot = 0; in_flush = 1'b0; m_ovf = 1'b0; m_unf = 1'b0;
      q.delete();
    end else begin
      bit p, o;
      p = exp_push();
      o = exp_pop();
      if (!in_flush && w_req && (wtot - rtot) == DEPTH) m_ovf = 1'b1;
      if (!in_flush && r_req && (wtot - rtot) == 0) m_unf = 1'b1;
      if (o) begin void'(q.pop_front()); rtot++; end
      if (p) begin q.push_back(wdata); wtot++; end
      if (flush_i) begin wtot = 0; rtot = 0; q.delete(); end
      in_flush = flush_i;
    end
  end

  task automatic step(input bit rst, input bit w, input bit r, input bit f);
    rst_i = rst; w_req = w; r_req = r; flush_i = f;
    wdata = 8'($urandom);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(); step(0, 0, 0, 0); endtask

  initial begin
    // Reset and fill
    step(1, 0, 0, 0);
    chk_en = 1'b1;
    chk("rst count", int'(count), 0);
    chk("rst empty", int'(empty), 1);
    chk("rst full", int'(full), 0);
    chk("rst w_Addr", int'(w_addr), 0);
    for (int i = 0; i < 8; i++) step(0, 1, 0, 0);
    chk("fill count", int'(count), 8);
    chk("fill full", int'(full), 1);
    step(0, 1, 0, 0);
    chk("push-on-full ovf", int'(ovf), 1);

    // Drain
    for (int i = 0; i < 8; i++) step(0, 0, 1, 0);
    chk("drain empty", int'(empty), 1);
    step(0, 0, 1, 0);
    chk("pop-on-empty unf", int'(unf), 1);
    chk("pop-on-empty r_Addr", int'(r_addr), 0);

    // Simultaneous push+pop at count 3, full, empty
    step(1, 0, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 1, 0, 0);
    step(0, 1, 1, 0);
    chk("pp count3", int'(count), 3);
    chk("pp w_Addr", int'(w_addr), 4);
    chk("pp r_Addr", int'(r_addr), 1);
    for (int i = 0; i < 5; i++) step(0, 1, 0, 0);
    step(0, 1, 1, 0);
    chk("pp full count", int'(count), 7);
    step(1, 0, 0, 0);
    step(0, 1, 1, 0);
    chk("pp empty count", int'(count), 1);

    // Wrap-around bursts
    step(1, 0, 0, 0);
    for (int k = 0; k < 4; k++) begin
      for (int i = 0; i < 5; i++) step(0, 1, 0, 0);
      for (int i = 0; i < 5; i++) step(0, 0, 1, 0);
    end
    chk("wrap w_Addr", int'(w_addr), 4);
    chk("wrap empty", int'(empty), 1);

    // Flush keeps sticky errors
    step(1, 0, 0, 0);
    step(0, 0, 1, 0);
    for (int i = 0; i < 5; i++) step(0, 1, 0, 0);
    step(0, 1, 0, 1);
    chk("flush count", int'(count), 0);
    chk("flush empty", int'(empty), 1);
    chk("flush keeps unf", int'(unf), 1);
    step(0, 1, 0, 0);
    chk("after FLUSH count", int'(count), 0);
    step(0, 1, 0, 0);
    chk("resume count", int'(count), 1);

    // Mid-burst reset
    for (int i = 0; i < 3; i++) step(0, 1, 0, 0);
    step(1, 1, 1, 0);
    chk("midrst count", int'(count), 0);
    chk("midrst unf", int'(unf), 0);

    // Watermark thresholds
    for (int i = 0; i < 6; i++) step(0, 1, 0, 0);
`ifdef FIFO_CTRL_WATERMARK_EN
    chk("af at 6", int'(af), 1);
`else
    chk("af tied", int'(af), 0);
`endif
    step(1, 0, 0, 0);
    step(0, 1, 0, 0);
    step(0, 1, 0, 0);
`ifdef FIFO_CTRL_WATERMARK_EN
    chk("ae at 2", int'(ae), 0);
`else
    chk("ae tied", int'(ae), 0);
`endif

    // Randomized traffic with drifting push/pop bias
    for (int c = 0; c < 3000; c++) begin
      int wp;
      wp = ((c / 64) % 3 == 0) ? 80 : (((c / 64) % 3 == 1) ? 20 : 50);
      step($urandom_range(0, 199) == 0,
           $urandom_range(0, 99) < wp,
           $urandom_range(0, 99) < (100 - wp),
           $urandom_range(0, 39) == 0);
    end
    idle();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
